// File: rtl/updown_count_checker.sv
// Observes an up/down counter's count stream, tracks its direction, and flags stalls, reversals, wraps and illegal steps.
// Optional build macro: UPDOWN_CHK_STRICT_EN (treats a direction reversal in TRACK as an illegal step).
module updown_count_checker #(
    parameter int WIDTH     = 9,
    parameter int ERR_LIMIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] count_in,
    output logic             dir_out,
    output logic             locked,
    output logic             stall,
    output logic             rev,
    output logic             wrap_up,
    output logic             wrap_down,
    output logic             step_err,
    output logic [7:0]       err_cnt,
    output logic             fault
);

    typedef enum logic [1:0] {IDLE, SYNC, TRACK, FAULT} state_t;

    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
    localparam logic [WIDTH-1:0] ALL1  = '1;
    localparam logic [7:0]       LIMIT = 8'(ERR_LIMIT);

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_prev, w_prev_nxt;
    logic             r_dir, w_dir_nxt;
    logic             r_locked;
    logic             r_stall, r_rev, r_wrap_up, r_wrap_dn, r_step_err;
    logic [7:0]       r_err_cnt, w_err_nxt;
    logic             r_fault, w_fault_nxt;

    logic             w_stall, w_rev, w_wrap_up, w_wrap_dn, w_err;
    logic [WIDTH-1:0] w_delta;
    logic             w_up, w_dn, w_zero, w_wup, w_wdn;
    logic [7:0]       w_err_inc;

    assign w_delta   = count_in - r_prev;
    assign w_up      = (w_delta == ONE);
    assign w_dn      = (w_delta == ALL1);
    assign w_zero    = (w_delta == '0);
    assign w_wup     = w_up && (r_prev == ALL1);
    assign w_wdn     = w_dn && (r_prev == '0);
    assign w_err_inc = (r_err_cnt == 8'hFF) ? 8'hFF : r_err_cnt + 8'd1;

    always_comb begin
        w_state_nxt = r_state;
        w_prev_nxt  = r_prev;
        w_dir_nxt   = r_dir;
        w_err_nxt   = r_err_cnt;
        w_fault_nxt = r_fault;
        w_stall     = 1'b0;
        w_rev       = 1'b0;
        w_wrap_up   = 1'b0;
        w_wrap_dn   = 1'b0;
        w_err       = 1'b0;
        if (en) begin
            case (r_state)
                IDLE: begin
                    w_prev_nxt  = count_in;
                    w_state_nxt = SYNC;
                end
                SYNC: begin
                    w_prev_nxt = count_in;
                    if (w_up || w_dn) begin
                        w_dir_nxt   = w_up;
                        w_state_nxt = TRACK;
                        w_wrap_up   = w_wup;
                        w_wrap_dn   = w_wdn;
                    end else if (w_zero) begin
                        w_stall = 1'b1;
                    end else begin
                        w_err = 1'b1;
                    end
                end
                TRACK: begin
                    w_prev_nxt = count_in;
                    if (w_zero) begin
                        w_stall = 1'b1;
                    end else if ((w_up && r_dir) || (w_dn && !r_dir)) begin
                        w_wrap_up = w_wup;
                        w_wrap_dn = w_wdn;
                    end else if (w_up || w_dn) begin
`ifdef UPDOWN_CHK_STRICT_EN
                        w_err = 1'b1;
`else
                        w_dir_nxt = ~r_dir;
                        w_rev     = 1'b1;
                        w_wrap_up = w_wup;
                        w_wrap_dn = w_wdn;
`endif
                    end else begin
                        w_err = 1'b1;
                    end
                end
                default: ;  // FAULT: frozen until reset
            endcase
            // The error that reaches the limit enters FAULT on the same edge
            if (w_err) begin
                w_err_nxt = w_err_inc;
                if (w_err_inc >= LIMIT) begin
                    w_state_nxt = FAULT;
                    w_fault_nxt = 1'b1;
                end else begin
                    w_state_nxt = SYNC;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_prev     <= '0;
            r_dir      <= 1'b0;
            r_locked   <= 1'b0;
            r_stall    <= 1'b0;
            r_rev      <= 1'b0;
            r_wrap_up  <= 1'b0;
            r_wrap_dn  <= 1'b0;
            r_step_err <= 1'b0;
            r_err_cnt  <= '0;
            r_fault    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_prev     <= w_prev_nxt;
            r_dir      <= w_dir_nxt;
            r_locked   <= (w_state_nxt == TRACK);
            r_stall    <= w_stall;
            r_rev      <= w_rev;
            r_wrap_up  <= w_wrap_up;
            r_wrap_dn  <= w_wrap_dn;
            r_step_err <= w_err;
            r_err_cnt  <= w_err_nxt;
            r_fault    <= w_fault_nxt;
        end
    end

    assign dir_out   = r_dir;
    assign locked    = r_locked;
    assign stall     = r_stall;
    assign rev       = r_rev;
    assign wrap_up   = r_wrap_up;
    assign wrap_down = r_wrap_dn;
    assign step_err  = r_step_err;
    assign err_cnt   = r_err_cnt;
    assign fault     = r_fault;

endmodule

// File: tb/tb_updown_count_checker.sv
// Directed bench for updown_count_checker; expected values are hand-derived per sample.
module tb_updown_count_checker;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic [8:0] count_in = '0;
    logic       dir_out, locked, stall, rev, wrap_up, wrap_down, step_err, fault;
    logic [7:0] err_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    updown_count_checker #(.WIDTH(9), .ERR_LIMIT(4)) dut (
        .clk(clk), .reset(reset), .en(en), .count_in(count_in),
        .dir_out(dir_out), .locked(locked), .stall(stall), .rev(rev),
        .wrap_up(wrap_up), .wrap_down(wrap_down), .step_err(step_err),
        .err_cnt(err_cnt), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Pulse vector order: {stall, rev, wrap_up, wrap_down, step_err}
    task automatic chk_flags(input string tag, input logic [4:0] exp);
        chk(tag, {27'd0, stall, rev, wrap_up, wrap_down, step_err}, {27'd0, exp});
    endtask

    task automatic smp(input logic [8:0] v);
        @(negedge clk);
        en       = 1'b1;
        count_in = v;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic en_val);
        @(negedge clk);
        reset    = 1'b1;
        en       = en_val;
        count_in = 9'd77;
        @(posedge clk);
        #1;
        @(negedge clk);
        reset = 1'b0;
        en    = 1'b0;
    endtask

    initial begin
        do_reset(1'b0);
        chk("rst_locked", locked, 0);
        chk("rst_err", err_cnt, 0);
        chk("rst_fault", fault, 0);
        chk("rst_dir", dir_out, 0);

        // Upward stream
        smp(9'd5);  chk("up5_locked", locked, 0); chk_flags("up5_flags", 5'b00000);
        smp(9'd6);  chk("up6_locked", locked, 1); chk("up6_dir", dir_out, 1);
        smp(9'd7);  chk_flags("up7_flags", 5'b00000);
        smp(9'd8);  chk("up8_err", err_cnt, 0); chk("up8_locked", locked, 1);

        // en low holds everything and gives no pulses
        @(negedge clk); en = 1'b0; count_in = 9'd300;
        @(posedge clk); #1;
        chk_flags("hold_flags", 5'b00000);
        chk("hold_locked", locked, 1);
        smp(9'd9);  chk_flags("hold_resume", 5'b00000); chk("hold_resume_lk", locked, 1);

        // Upward wrap then reversal and downward wrap
        do_reset(1'b0);
        smp(9'd510); chk_flags("w510", 5'b00000);
        smp(9'd511); chk_flags("w511", 5'b00000); chk("w511_lk", locked, 1);
        smp(9'd0);   chk_flags("w0_wrapup", 5'b00100);
        smp(9'd1);   chk_flags("w1", 5'b00000);
`ifdef UPDOWN_CHK_STRICT_EN
        smp(9'd0);   chk_flags("strict_rev", 5'b00001);
        chk("strict_rev_lk", locked, 0);
        chk("strict_rev_err", err_cnt, 1);
`else
        smp(9'd0);   chk_flags("rev_at0", 5'b01000); chk("rev_dir", dir_out, 0);
        smp(9'd511); chk_flags("wrapdn", 5'b00010); chk("wrapdn_dir", dir_out, 0);
        chk("wrapdn_lk", locked, 1);
`endif

        // Stall
        do_reset(1'b0);
        smp(9'd20); smp(9'd21);
        smp(9'd21); chk_flags("stall_pulse", 5'b10000); chk("stall_lk", locked, 1);
        smp(9'd22); chk_flags("stall_clear", 5'b00000); chk("stall_lk2", locked, 1);

        // Single illegal step and relock
        do_reset(1'b0);
        smp(9'd30); smp(9'd31);
        smp(9'd40); chk_flags("jump_err", 5'b00001); chk("jump_lk", locked, 0);
        chk("jump_cnt", err_cnt, 1);
        smp(9'd41); chk("relock", locked, 1); chk_flags("relock_flags", 5'b00000);
        chk("relock_cnt", err_cnt, 1);

        // Four errors reach FAULT on the fourth
        do_reset(1'b0);
        smp(9'd100);
        smp(9'd110); chk("e1_cnt", err_cnt, 1); chk("e1_fault", fault, 0);
        smp(9'd120); chk("e2_cnt", err_cnt, 2);
        smp(9'd130); chk("e3_cnt", err_cnt, 3); chk("e3_fault", fault, 0);
        smp(9'd140); chk_flags("e4_flags", 5'b00001); chk("e4_fault", fault, 1);
        chk("e4_cnt", err_cnt, 4);
        smp(9'd141); chk_flags("flt_legal", 5'b00000); chk("flt_cnt", err_cnt, 4);
        chk("flt_lk", locked, 0);
        smp(9'd141); chk_flags("flt_stall", 5'b00000);
        smp(9'd300); chk_flags("flt_jump", 5'b00000); chk("flt_cnt2", err_cnt, 4);
        chk("flt_sticky", fault, 1);

        // Reset wins over en
        do_reset(1'b1);
        chk("fr_fault", fault, 0);
        chk("fr_cnt", err_cnt, 0);
        chk("fr_lk", locked, 0);
        chk("fr_dir", dir_out, 0);
        chk_flags("fr_flags", 5'b00000);
        smp(9'd200); chk("post_first_lk", locked, 0); chk_flags("post_first", 5'b00000);
        smp(9'd199); chk("post_lk", locked, 1); chk("post_dir", dir_out, 0);

`ifdef UPDOWN_CHK_STRICT_EN
        do_reset(1'b0);
        smp(9'd10); smp(9'd11);
        smp(9'd10); chk_flags("s_flags", 5'b00001); chk("s_cnt", err_cnt, 1);
        chk("s_lk", locked, 0);
`else
        do_reset(1'b0);
        smp(9'd10); smp(9'd11);
        smp(9'd10); chk_flags("r_flags", 5'b01000); chk("r_cnt", err_cnt, 0);
        chk("r_lk", locked, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
